vic_prio_wb: RTL and testbench
==============================

VIC_PRIO_WB -- requirements
Module: vic_prio_wb

Interface
REQ-001 Parameter NCH, default 4: number of interrupt channels, legal range 1..16.
REQ-002 Parameter SPUR_VEC, default 16'o000000: vector returned on a spurious fetch (used only when VIC_SPURIOUS_EN is defined).
REQ-003 clk_sys  in  1  system clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 ce  in  1  bus clock enable; all state except iack updates only on clk_sys edges with ce=1.
REQ-006 wb_rst_i  in  1  synchronous bus INIT, active-high, sampled on ce.
REQ-007 wb_stb_i  in  1  vector-fetch strobe (IAKO read cycle).
REQ-008 wb_ack_o  out  1  vector-fetch acknowledge (RPLY).
REQ-009 wb_dat_o  out  16  vector data, 0 when not acknowledging.
REQ-010 wb_irq_o  out  1  vectored interrupt request (VIRQ) to CPU.
REQ-011 ivec  in  NCH*16  channel vectors; channel i at bits [16*i+15:16*i].
REQ-012 ireq  in  NCH  per-channel request inputs.
REQ-013 imask  in  NCH  per-channel mask, 1 = masked (pending retained, not requested).
REQ-014 iedge  in  NCH  per-channel mode, 1 = rising-edge latched, 0 = level.
REQ-015 iack  out  NCH  one-hot acknowledge pulse to the serviced channel.

Function
REQ-016 Edge channel: pending[i] sets on a ce edge where ireq[i]=1 and the previous ce sample was 0; clears when channel i is acknowledged.
REQ-017 Edge channel: set and acknowledge in the same ce cycle leave pending[i]=1 (new event never lost).
REQ-018 Level channel: pending[i] equals ireq[i] sampled at each ce; acknowledge does not clear it.
REQ-019 wb_irq_o is registered: equals OR(pending & ~imask) as of the previous ce edge; ireq rise to wb_irq_o=1 is 2 ce cycles.
REQ-020 Priority: highest-index unmasked pending channel wins; fixed, no rotation.
REQ-021 FSM states IDLE, ACK; IDLE -> ACK on ce with wb_stb_i=1 and an unmasked pending channel.
REQ-022 On IDLE->ACK: winner index latched, wb_dat_o=ivec[winner], wb_ack_o=1, iack[winner] pulses for exactly one clk_sys cycle.
REQ-023 Winner, data and ack held stable in ACK regardless of later ireq/imask changes.
REQ-024 ACK -> IDLE on ce with wb_stb_i=0; wb_ack_o=0 and wb_dat_o=0 at that edge.
REQ-025 wb_irq_o is forced 0 while in ACK and recomputes on the first ce after returning to IDLE.
REQ-026 wb_stb_i=1 with no unmasked pending channel: remain IDLE, no ack, no iack (bus timeout), unless REQ-033 applies.
REQ-027 Changing imask/iedge takes effect at the next ce; switching a channel edge->level clears its pending bit.
REQ-028 wb_rst_i=1 on ce: all pending, sample history, FSM, wb_ack_o, wb_dat_o, wb_irq_o cleared, including mid-ACK.
REQ-029 Ports pass through unchanged for NCH=1; priority encoder and mux width scale with NCH.

Reset
REQ-030 reset_n=0 asynchronously forces: state IDLE, pending=0, sample history=0, wb_ack_o=0, wb_dat_o=0, wb_irq_o=0, iack=0.
REQ-031 ireq held high through reset release produces no edge event on edge channels (history reset to 0 but first sample after release counts as edge only if ireq rises after it).
REQ-032 No output changes until the first ce after reset_n deasserts.

Configuration
REQ-033 Macro VIC_SPURIOUS_EN defined: spurious fetch (REQ-026 condition) enters ACK, returns SPUR_VEC, wb_ack_o=1, no iack pulse; undefined: spurious fetch is never acknowledged.

Verification
REQ-034 NCH=2, ivec={16'o000060,16'o000274}, edge ch1 ireq pulse -> wb_irq_o=1 after 2 ce; fetch returns 16'o000060, iack=2'b10 one clk_sys cycle, pending cleared.
REQ-035 ch0 and ch1 both pending, fetch -> 16'o000060 first, second fetch -> 16'o000274, then wb_irq_o=0.
REQ-036 ch1 masked and pending, ch0 pending -> fetch returns 16'o000274; unmask ch1 -> wb_irq_o=1, fetch returns 16'o000060.
REQ-037 Level ch0 held high across fetch -> 16'o000274 acked, wb_irq_o reasserts after return to IDLE; edge ch re-pulse during ACK of same channel -> stays pending.
REQ-038 Fetch with nothing pending -> no ack (macro undefined); ack with SPUR_VEC=16'o000004 and iack=0 (macro defined).
REQ-039 reset_n low mid-ACK -> wb_ack_o, wb_dat_o, wb_irq_o=0 immediately; wb_rst_i on ce mid-ACK -> same at that edge.

Source files
------------

// File: rtl/vic_prio_wb_if.sv
// Vector-fetch bus between the CPU (master) and the priority interrupt controller (slave).
interface vic_prio_wb_if;
  logic        wb_stb_i;
  logic        wb_ack_o;
  logic [15:0] wb_dat_o;
  logic        wb_irq_o;

  modport master (output wb_stb_i, input wb_ack_o, wb_dat_o, wb_irq_o);
  modport slave  (input wb_stb_i, output wb_ack_o, wb_dat_o, wb_irq_o);
endinterface

// File: rtl/vic_prio_wb.sv
// Fixed-priority vectored interrupt controller, highest index wins; irq is 2 ce after an ireq rise.
// Ack holds until the strobe drops. Define VIC_SPURIOUS_EN to answer empty fetches with SPUR_VEC.
module vic_prio_wb #(
  parameter int          NCH      = 4,
  parameter logic [15:0] SPUR_VEC = 16'o000000
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ce,
  input  logic              wb_rst_i,
  vic_prio_wb_if.slave      bus,
  input  logic [NCH*16-1:0] ivec,
  input  logic [NCH-1:0]    ireq,
  input  logic [NCH-1:0]    imask,
  input  logic [NCH-1:0]    iedge,
  output logic [NCH-1:0]    iack
);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t         state_q, state_d;
  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] hist_q, hist_d;
  logic [NCH-1:0] iack_q, iack_d;
  logic           hist_vld_q, hist_vld_d;
  logic           ack_q, ack_d;
  logic           irq_q, irq_d;
  logic [15:0]    dat_q, dat_d;

  logic [NCH-1:0] avail;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] clr;
  logic [IW-1:0]  win;
  logic [15:0]    wvec;
  logic           any;
  logic           grant;
  logic           spur;

  always_comb begin
    avail = pend_q & ~imask;
    any   = |avail;
    win   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (avail[i]) win = IW'(i);
    end
    wvec = '0;
    for (int i = 0; i < NCH; i++) begin
      if (IW'(i) == win) wvec = ivec[16*i +: 16];
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    hist_d     = hist_q;
    hist_vld_d = hist_vld_q;
    ack_d      = ack_q;
    dat_d      = dat_q;
    irq_d      = irq_q;
    iack_d     = '0;
    grant      = 1'b0;
    spur       = 1'b0;
    clr        = '0;
    rise       = '0;
    if (ce) begin
      if (wb_rst_i) begin
        state_d    = S_IDLE;
        pend_d     = '0;
        hist_d     = '0;
        hist_vld_d = 1'b0;
        ack_d      = 1'b0;
        dat_d      = '0;
        irq_d      = 1'b0;
      end else begin
        grant = (state_q == S_IDLE) && bus.wb_stb_i && any;
`ifdef VIC_SPURIOUS_EN
        spur  = (state_q == S_IDLE) && bus.wb_stb_i && !any;
`endif
        if (grant) clr = NCH'(1) << win;
        // The first sample after reset only primes history, so a held-high ireq is not an edge.
        rise       = ireq & ~hist_q & {NCH{hist_vld_q}};
        pend_d     = (iedge & (rise | (pend_q & ~clr))) | (~iedge & ireq);
        hist_d     = ireq;
        hist_vld_d = 1'b1;
        case (state_q)
          S_IDLE: begin
            if (grant || spur) begin
              state_d = S_ACK;
              ack_d   = 1'b1;
              dat_d   = grant ? wvec : SPUR_VEC;
              irq_d   = 1'b0;
              iack_d  = clr;
            end else begin
              irq_d = any;
            end
          end
          S_ACK: begin
            irq_d = 1'b0;
            if (!bus.wb_stb_i) begin
              state_d = S_IDLE;
              ack_d   = 1'b0;
              dat_d   = '0;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      pend_q     <= '0;
      hist_q     <= '0;
      hist_vld_q <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      irq_q      <= 1'b0;
      iack_q     <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      hist_q     <= hist_d;
      hist_vld_q <= hist_vld_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      irq_q      <= irq_d;
      iack_q     <= iack_d;
    end
  end

  assign bus.wb_ack_o = ack_q;
  assign bus.wb_dat_o = dat_q;
  assign bus.wb_irq_o = irq_q;
  assign iack         = iack_q;
endmodule

// File: tb/tb_vic_prio_wb.sv
// Bench for vic_prio_wb with two channels: directed vector table, reset corner sequences, random vs. model.
module tb_vic_prio_wb;
  localparam int          NCH = 2;
  localparam logic [15:0] V1  = 16'o000060;
  localparam logic [15:0] V0  = 16'o000274;
  localparam logic [15:0] SV  = 16'o000004;
`ifdef VIC_SPURIOUS_EN
  localparam bit SPUR_ON = 1'b1;
`else
  localparam bit SPUR_ON = 1'b0;
`endif

  logic           clk_sys = 1'b0;
  logic           reset_n;
  logic           ce;
  logic           wb_rst_i;
  logic [NCH*16-1:0] ivec;
  logic [NCH-1:0] ireq, imask, iedge, iack;

  vic_prio_wb_if bus ();

  vic_prio_wb #(.NCH(NCH), .SPUR_VEC(SV)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .ce      (ce),
    .wb_rst_i(wb_rst_i),
    .bus     (bus),
    .ivec    (ivec),
    .ireq    (ireq),
    .imask   (imask),
    .iedge   (iedge),
    .iack    (iack)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    bit          c;
    bit          stb;
    logic [1:0]  rq, mk, ed;
    bit          e_ack;
    logic [15:0] e_dat;
    bit          e_irq;
    logic [1:0]  e_iack;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // reference model state
  logic [1:0]  m_pend, m_hist, m_iack;
  bit          m_armed, m_busy, m_ack, m_irq;
  logic [15:0] m_dat;
  logic [15:0] vecs [2];

  function automatic void add(bit c, bit stb, logic [1:0] rq, logic [1:0] mk, logic [1:0] ed,
                              bit a, logic [15:0] d, bit irq, logic [1:0] ia);
    vec_t v;
    v.c = c; v.stb = stb; v.rq = rq; v.mk = mk; v.ed = ed;
    v.e_ack = a; v.e_dat = d; v.e_irq = irq; v.e_iack = ia;
    tbl.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(string nm, bit a, logic [15:0] d, bit irq, logic [1:0] ia);
    n_tests++;
    if (bus.wb_ack_o !== a || bus.wb_dat_o !== d || bus.wb_irq_o !== irq || iack !== ia) begin
      n_fail++;
      $display("FAIL %s: got ack=%0b dat=%o irq=%0b iack=%b, want ack=%0b dat=%o irq=%0b iack=%b",
               nm, bus.wb_ack_o, bus.wb_dat_o, bus.wb_irq_o, iack, a, d, irq, ia);
    end
  endtask

  task automatic model_clear();
    m_pend = '0; m_hist = '0; m_armed = 0; m_busy = 0;
    m_ack = 0; m_dat = '0; m_irq = 0; m_iack = '0;
  endtask

  // One clk_sys edge of the controller, stated from the behavioural rules.
  task automatic model_step(bit c, bit r, bit s, logic [1:0] rq, logic [1:0] mk, logic [1:0] ed);
    int w;
    logic [1:0] np;
    m_iack = '0;
    if (!c) return;
    if (r) begin
      model_clear();
      return;
    end
    w = -1;
    for (int i = 0; i < 2; i++) if (m_pend[i] && !mk[i]) w = i;
    np = m_pend;
    for (int i = 0; i < 2; i++) begin
      if (!ed[i]) np[i] = rq[i];
      else begin
        if (!m_busy && s && w == i) np[i] = 1'b0;
        if (m_armed && rq[i] && !m_hist[i]) np[i] = 1'b1;
      end
    end
    if (m_busy) begin
      m_irq = 0;
      if (!s) begin m_busy = 0; m_ack = 0; m_dat = '0; end
    end else if (s && w >= 0) begin
      m_busy = 1; m_ack = 1; m_dat = vecs[w]; m_iack[w] = 1'b1; m_irq = 0;
    end else if (s && SPUR_ON) begin
      m_busy = 1; m_ack = 1; m_dat = SV; m_irq = 0;
    end else begin
      m_irq = (w >= 0);
    end
    m_pend  = np;
    m_hist  = rq;
    m_armed = 1;
  endtask

  initial begin
    vecs[0] = V0;
    vecs[1] = V1;
    ivec = {V1, V0};
    reset_n = 1'b0; ce = 1'b0; wb_rst_i = 1'b0;
    bus.wb_stb_i = 1'b0; ireq = '0; imask = '0; iedge = 2'b11;
    repeat (2) tick();
    check("reset_state", 0, '0, 0, 2'b00);
    reset_n = 1'b1;
    tick();
    check("idle_without_ce", 0, '0, 0, 2'b00);

    // c stb  rq     mk     ed     ack dat irq iack
    add(1,0,2'b00,2'b00,2'b11, 0,'0,0,2'b00);
    add(1,0,2'b10,2'b00,2'b11, 0,'0,0,2'b00);
    add(1,0,2'b00,2'b00,2'b11, 0,'0,1,2'b00);
    add(0,1,2'b00,2'b00,2'b11, 0,'0,1,2'b00);
    add(1,1,2'b00,2'b00,2'b11, 1,V1,0,2'b10);
    add(0,1,2'b00,2'b00,2'b11, 1,V1,0,2'b00);
    add(1,1,2'b00,2'b00,2'b11, 1,V1,0,2'b00);
    add(1,0,2'b00,2'b00,2'b11, 0,'0,0,2'b00);
    add(1,0,2'b00,2'b00,2'b11, 0,'0,0,2'b00);
    // both channels pending
    add(1,0,2'b11,2'b00,2'b11, 0,'0,0,2'b00);
    add(1,0,2'b00,2'b00,2'b11, 0,'0,1,2'b00);
    add(1,1,2'b00,2'b00,2'b11, 1,V1,0,2'b10);
    add(1,0,2'b00,2'b00,2'b11, 0,'0,0,2'b00);
    add(1,0,2'b00,2'b00,2'b11, 0,'0,1,2'b00);
    add(1,1,2'b00,2'b00,2'b11, 1,V0,0,2'b01);
    add(1,0,2'b00,2'b00,2'b11, 0,'0,0,2'b00);
    add(1,0,2'b00,2'b00,2'b11, 0,'0,0,2'b00);
    // ch1 masked while pending
    add(1,0,2'b11,2'b10,2'b11, 0,'0,0,2'b00);
    add(1,0,2'b00,2'b10,2'b11, 0,'0,1,2'b00);
    add(1,1,2'b00,2'b10,2'b11, 1,V0,0,2'b01);
    add(1,0,2'b00,2'b10,2'b11, 0,'0,0,2'b00);
    add(1,0,2'b00,2'b10,2'b11, 0,'0,0,2'b00);
    add(1,0,2'b00,2'b00,2'b11, 0,'0,1,2'b00);
    add(1,1,2'b00,2'b00,2'b11, 1,V1,0,2'b10);
    add(1,0,2'b00,2'b00,2'b11, 0,'0,0,2'b00);
    add(1,0,2'b00,2'b00,2'b11, 0,'0,0,2'b00);
    // ch0 level, held across the fetch
    add(1,0,2'b01,2'b00,2'b10, 0,'0,0,2'b00);
    add(1,0,2'b01,2'b00,2'b10, 0,'0,1,2'b00);
    add(1,1,2'b01,2'b00,2'b10, 1,V0,0,2'b01);
    add(1,0,2'b01,2'b00,2'b10, 0,'0,0,2'b00);
    add(1,0,2'b01,2'b00,2'b10, 0,'0,1,2'b00);
    add(1,0,2'b00,2'b00,2'b10, 0,'0,1,2'b00);
    add(1,0,2'b00,2'b00,2'b10, 0,'0,0,2'b00);
    // ch1 re-pulses while its own fetch is in ACK
    add(1,0,2'b10,2'b00,2'b10, 0,'0,0,2'b00);
    add(1,0,2'b00,2'b00,2'b10, 0,'0,1,2'b00);
    add(1,1,2'b00,2'b00,2'b10, 1,V1,0,2'b10);
    add(1,1,2'b10,2'b00,2'b10, 1,V1,0,2'b00);
    add(1,0,2'b00,2'b00,2'b10, 0,'0,0,2'b00);
    add(1,0,2'b00,2'b00,2'b10, 0,'0,1,2'b00);
    add(1,1,2'b00,2'b00,2'b10, 1,V1,0,2'b10);
    add(1,0,2'b00,2'b00,2'b10, 0,'0,0,2'b00);
    add(1,0,2'b00,2'b00,2'b10, 0,'0,0,2'b00);
    // new edge on the very edge that acknowledges it
    add(1,0,2'b10,2'b00,2'b11, 0,'0,0,2'b00);
    add(1,0,2'b00,2'b00,2'b11, 0,'0,1,2'b00);
    add(1,1,2'b10,2'b00,2'b11, 1,V1,0,2'b10);
    add(1,0,2'b10,2'b00,2'b11, 0,'0,0,2'b00);
    add(1,0,2'b00,2'b00,2'b11, 0,'0,1,2'b00);
    add(1,1,2'b00,2'b00,2'b11, 1,V1,0,2'b10);
    add(1,0,2'b00,2'b00,2'b11, 0,'0,0,2'b00);
    add(1,0,2'b00,2'b00,2'b11, 0,'0,0,2'b00);
    // fetch with nothing pending
    add(1,1,2'b00,2'b00,2'b11, SPUR_ON, SPUR_ON ? SV : 16'h0000, 0,2'b00);
    add(1,0,2'b00,2'b00,2'b11, 0,'0,0,2'b00);
    // edge -> level switch drops a latched event
    add(1,0,2'b10,2'b00,2'b11, 0,'0,0,2'b00);
    add(1,0,2'b00,2'b00,2'b00, 0,'0,1,2'b00);
    add(1,0,2'b00,2'b00,2'b00, 0,'0,0,2'b00);

    foreach (tbl[k]) begin
      ce = tbl[k].c; bus.wb_stb_i = tbl[k].stb;
      ireq = tbl[k].rq; imask = tbl[k].mk; iedge = tbl[k].ed;
      tick();
      check($sformatf("row%0d", k), tbl[k].e_ack, tbl[k].e_dat, tbl[k].e_irq, tbl[k].e_iack);
    end

    // async reset in the middle of an ACK, then ireq held high through release
    ce = 1; imask = '0; iedge = 2'b11; bus.wb_stb_i = 0;
    ireq = 2'b10; tick();
    ireq = 2'b00; tick();
    bus.wb_stb_i = 1; tick();
    check("seqA_enter_ack", 1, V1, 0, 2'b10);
    #2 reset_n = 1'b0;
    #1 check("async_rst_mid_ack", 0, '0, 0, 2'b00);
    bus.wb_stb_i = 0; ireq = 2'b10;
    tick();
    reset_n = 1'b1; ce = 0;
    tick();
    check("hold_until_ce", 0, '0, 0, 2'b00);
    ce = 1;
    repeat (4) tick();
    check("no_edge_held_high", 0, '0, 0, 2'b00);
    ireq = 2'b00; tick();
    ireq = 2'b10; tick();
    ireq = 2'b00; tick();
    check("edge_after_rst", 0, '0, 1, 2'b00);

    // bus INIT in the middle of an ACK
    bus.wb_stb_i = 1; tick();
    check("seqB_enter_ack", 1, V1, 0, 2'b10);
    wb_rst_i = 1; tick();
    check("sync_rst_mid_ack", 0, '0, 0, 2'b00);
    wb_rst_i = 0; bus.wb_stb_i = 0;
    tick(); tick();
    check("pend_cleared_by_init", 0, '0, 0, 2'b00);

    // random traffic against the model
    ce = 1; wb_rst_i = 1; tick();
    wb_rst_i = 0;
    model_clear();
    for (int k = 0; k < 3000; k++) begin
      bit c, r, s;
      logic [1:0] rq, mk, ed;
      c  = ($urandom_range(3) != 0);
      r  = ($urandom_range(63) == 0);
      s  = ($urandom_range(2) == 0) ? ~bus.wb_stb_i : bus.wb_stb_i;
      rq = 2'($urandom);
      mk = ($urandom_range(3) == 0) ? 2'($urandom) : 2'b00;
      ed = ($urandom_range(15) == 0) ? 2'($urandom) : iedge;
      ce = c; wb_rst_i = r; bus.wb_stb_i = s; ireq = rq; imask = mk; iedge = ed;
      tick();
      model_step(c, r, s, rq, mk, ed);
      check($sformatf("rand%0d", k), m_ack, m_dat, m_irq, m_iack);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
